// File: rtl/addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
// Imported by serial_addsub and its full-adder cell.
package addsub_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} addsub_state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/full_adder_bit.sv
// Combinational one-bit full-adder cell.
// Zero latency; no flow control.
module full_adder_bit
  import addsub_pkg::*;
(
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: one full-adder cell reused over WIDTH cycles, LSB first.
// Result latency WIDTH cycles from accepted start; start is ignored while busy.
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  addsub_state_t    r_state;
  addsub_state_t    w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_s;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             w_sum;
  logic             w_carry;
  logic             w_inv;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_acc_nxt;

  full_adder_bit u_fa (
    .A    (r_a[0]),
    .B    (r_b[0]),
    .Cin  (r_carry),
    .S    (w_sum),
    .Cout (w_carry)
  );

  // Subtraction is A + ~B + ~Cin, so the borrow-in becomes an inverted carry-in.
  assign w_inv     = (Sub == MODE_SUB);
  assign w_accept  = start && (r_state != RUN);
  assign w_last    = (r_state == RUN) && (r_cnt == CNT_W'(WIDTH - 1));
  assign w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = start ? RUN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_s     <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_a     <= A;
        r_b     <= B ^ {WIDTH{w_inv}};
        r_carry <= Cin ^ w_inv;
        r_cnt   <= '0;
        r_acc   <= '0;
      end else if (r_state == RUN) begin
        r_acc   <= w_acc_nxt;
        r_carry <= w_carry;
        r_a     <= r_a >> 1;
        r_b     <= r_b >> 1;
        r_cnt   <= r_cnt + CNT_W'(1);
        // On the MSB step r_carry is the carry into the MSB.
        if (w_last) begin
          r_s    <= w_acc_nxt;
          r_cout <= w_carry;
          r_ovf  <= r_carry ^ w_carry;
        end
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign S    = r_s;
  assign Cout = r_cout;
  assign Ovf  = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// Randomized and directed bench for serial_addsub against an arithmetic reference model.
module tb_serial_addsub;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic         Sub;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         busy;
  logic         done;
  logic [W-1:0] S;
  logic         Cout;
  logic         Ovf;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] held_s;
  logic         held_c;
  logic         held_o;

  serial_addsub #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .Sub   (Sub),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .Cout  (Cout),
    .Ovf   (Ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub, input logic cin);
    longint ua, ub, sa, sb, ci, u, sres, lim;
    logic [63:0] ubits;
    logic c, o;
    lim  = longint'(1) << W;
    ua   = longint'(a);
    ub   = longint'(b);
    ci   = cin ? 64'sd1 : 64'sd0;
    sa   = a[W-1] ? ua - lim : ua;
    sb   = b[W-1] ? ub - lim : ub;
    if (!sub) begin
      u    = ua + ub + ci;
      sres = sa + sb + ci;
      c    = (u >= lim);
    end else begin
      u    = ua - ub - ci;
      sres = sa - sb - ci;
      c    = (u >= 0);
    end
    o     = (sres > (lim / 2) - 1) || (sres < -(lim / 2));
    ubits = u;
    return {o, c, ubits[W-1:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic cin);
    A     = a;
    B     = b;
    Sub   = sub;
    Cin   = cin;
    start = 1'b1;
  endtask

  // Called just after edge t0; walks edges t0+1..t0+W. A nonzero poke raises start
  // so that it is sampled at edge t0+poke, while the block is running.
  task automatic expect_run(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic sub, input logic cin, input int poke);
    logic [W+1:0] r;
    r = model(a, b, sub, cin);
    for (int k = 1; k <= W; k++) begin
      @(posedge clk);
      #1;
      if (k < W) begin
        check("busy_run", busy, 1);
        check("done_early", done, 0);
        check("s_hold_run", S, held_s);
      end else begin
        check("done_pulse", done, 1);
        check("busy_done", busy, 0);
        check("sum", S, r[W-1:0]);
        check("cout", Cout, r[W]);
        check("ovf", Ovf, r[W+1]);
      end
      if (poke != 0 && k == poke - 1) begin
        start = 1'b1;
        A     = W'($urandom);
        B     = W'($urandom);
        Cin   = ~Cin;
      end
      if (poke != 0 && k == poke) start = 1'b0;
    end
    held_s = r[W-1:0];
    held_c = r[W];
    held_o = r[W+1];
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic cin, input int poke);
    launch(a, b, sub, cin);
    @(posedge clk);
    #1;
    start = 1'b0;
    expect_run(a, b, sub, cin, poke);
    @(posedge clk);
    #1;
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    check("idle_s_hold", S, held_s);
    check("idle_c_hold", Cout, held_c);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    Sub    = 1'b0;
    A      = '0;
    B      = '0;
    Cin    = 1'b0;
    held_s = '0;
    held_c = 1'b0;
    held_o = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_s", S, 0);
    check("rst_cout", Cout, 0);
    check("rst_ovf", Ovf, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_op(8'h3C, 8'h0F, 1'b0, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b1, 0);
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, 0);
    run_op(8'h80, 8'h01, 1'b1, 1'b0, 0);
    run_op(8'h05, 8'h07, 1'b1, 1'b0, 0);
    run_op(8'h05, 8'h02, 1'b1, 1'b1, 0);

    // Start raised in RUN must not disturb the running operation.
    run_op(8'h12, 8'h34, 1'b0, 1'b1, 3);

    // Start held through DONE restarts straight from DONE into RUN.
    launch(8'hA5, 8'h5A, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    A   = 8'h40;
    B   = 8'hC1;
    Sub = 1'b1;
    Cin = 1'b0;
    expect_run(8'hA5, 8'h5A, 1'b0, 1'b1, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_busy", busy, 1);
    check("b2b_done", done, 0);
    expect_run(8'h40, 8'hC1, 1'b1, 1'b0, 0);
    @(posedge clk);
    #1;
    check("b2b_idle", busy, 0);

    // Reset mid-operation aborts with no done pulse and clears the result.
    launch(8'h11, 8'h22, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_s", S, 0);
    check("mid_rst_cout", Cout, 0);
    check("mid_rst_ovf", Ovf, 0);
    held_s = '0;
    held_c = 1'b0;
    held_o = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("aborted_no_done", done, 0);
    end
    run_op(8'h9C, 8'h27, 1'b1, 1'b1, 0);

    for (int n = 0; n < 30; n++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
